// File: rtl/cnet_reg_master.sv
`default_nettype none
// ============================================================================
// Module      : cnet_reg_master
// Description : CPCI-side single-outstanding register initiator for the
//               CPCI->CNET path, with issue/read-response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cnet_reg_master #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wr_data,
  output logic        host_busy,
  output logic        host_done,
  output logic        host_err,
  output logic [31:0] host_rd_data,
  output logic [31:0] p2n_data,
  output logic [31:0] p2n_addr,
  output logic        p2n_we,
  output logic        p2n_req,
  input  logic        p2n_full,
  input  logic [31:0] n2p_data,
  input  logic        n2p_rd_rdy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Last counter value before abort; TIMEOUT <= 255 keeps the 8-bit counter from wrapping.
  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_cnt;

  assign host_busy = (r_state != S_IDLE);
  assign host_done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      host_err     <= 1'b0;
      host_rd_data <= 32'd0;
      p2n_data     <= 32'd0;
      p2n_addr     <= 32'd0;
      p2n_we       <= 1'b0;
      p2n_req      <= 1'b0;
    end else begin
      p2n_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (host_req) begin
            p2n_we   <= host_we;
            p2n_addr <= host_addr;
            p2n_data <= host_we ? host_wr_data : 32'd0;
            host_err <= 1'b0;
            r_cnt    <= 8'd0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!p2n_full) begin
            p2n_req <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= p2n_we ? S_DONE : S_WAIT_RD;
          end else if (r_cnt == c_CNT_LAST) begin
            host_err <= 1'b1;
            if (!p2n_we) begin
              host_rd_data <= ERR_DATA;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT_RD: begin
          // A response on the timeout edge still counts as success.
          if (n2p_rd_rdy) begin
            host_rd_data <= n2p_data;
            host_err     <= 1'b0;
            r_state      <= S_DONE;
          end else if (r_cnt == c_CNT_LAST) begin
            host_rd_data <= ERR_DATA;
            host_err     <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_cnt   <= 8'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cnet_reg_master.md
Name: cnet_reg_master

Overview:
- CPCI-side initiator for the CPCI->CNET register path.
- Accepts single register read/write commands from a host-side requester and issues them on the p2n_* request interface, honouring p2n_full.
- For reads, waits for the n2p_rd_rdy response, with a timeout, and returns the data to the host.
- Supports one transaction in flight at a time.

Parameters:
TIMEOUT, 64, cycles allowed in ISSUE (waiting for p2n_full low) or WAIT_RD (waiting for n2p_rd_rdy) before aborting with error; legal range 2..255
ERR_DATA, 32'hFFFF_FFFF, value loaded into host_rd_data on a read abort

Ports:
clk  input  1  single clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
host_req  input  1  command strobe; sampled only while host_busy=0
host_we  input  1  1=write, 0=read; sampled with host_req
host_addr  input  32  register address; sampled with host_req
host_wr_data  input  32  write data; sampled with host_req
host_busy  output  1  transaction in progress
host_done  output  1  one-cycle completion pulse
host_err  output  1  valid with host_done; 1=timeout abort
host_rd_data  output  32  read result; held until next read completes
p2n_data  output  32  write data to CNET
p2n_addr  output  32  address to CNET
p2n_we  output  1  write enable to CNET
p2n_req  output  1  one-cycle request strobe to CNET
p2n_full  input  1  CNET request buffer full; do not issue while high
n2p_data  input  32  read data from CNET
n2p_rd_rdy  input  1  read data valid, one cycle

Behaviour:
- Reset (reset_n=0, async):
  - State=IDLE.
  - All outputs 0, including host_rd_data.
  - Timeout counter 0.
  - Any in-flight transaction is discarded; no host_done is issued for it.
  - p2n_req drops immediately.
- All outputs registered except host_busy and host_done:
  - host_busy = (state != IDLE).
  - host_done = (state == DONE).
- IDLE:
  - host_req=1 latches host_we/host_addr/host_wr_data into p2n_we/p2n_addr/p2n_data, then -> ISSUE.
  - p2n_data is loaded 0 for reads.
  - p2n_addr/p2n_data/p2n_we hold stable until the next accepted command.
- ISSUE:
  - counter increments each cycle.
  - p2n_full=0 at edge: p2n_req<=1 for exactly one cycle; counter<=0; write -> DONE (err=0), read -> WAIT_RD.
  - p2n_full=1 and counter==TIMEOUT-1: no request issued; host_err<=1; read also loads host_rd_data<=ERR_DATA; -> DONE.
  - otherwise stay in ISSUE with p2n_req=0.
- WAIT_RD:
  - counter increments each cycle.
  - n2p_rd_rdy=1: host_rd_data<=n2p_data; host_err<=0; -> DONE.
  - counter==TIMEOUT-1 with no rd_rdy: host_rd_data<=ERR_DATA; host_err<=1; -> DONE.
  - rd_rdy on the same edge as timeout: rd_rdy wins, err=0.
- DONE:
  - one cycle, -> IDLE; host_err is valid in this cycle.
  - host_err clears on the next accepted command.
- host_req while host_busy=1: ignored, not queued.
- host_req in the same cycle as DONE: ignored, because host_busy is still 1.
- A new command may be accepted the cycle after DONE.
- n2p_rd_rdy outside WAIT_RD: ignored; host_rd_data unchanged.
- Latency, write, full low:
  - host_req sampled edge0; ISSUE after edge0.
  - p2n_req and host_done both high in the cycle after edge1.
  - Back in IDLE after edge2.
- Latency, read: p2n_req after edge1; host_done the cycle after the edge that samples n2p_rd_rdy.
- Counter is 8 bits and never wraps: the TIMEOUT compare fires first.

Test Plan:
1. Write path:
   - Stimulus: host write addr=32'h0000_0040, data=32'hA5A5_0001; CNET emulator with buf_size=4.
   - Response: p2n_req high exactly 1 cycle with p2n_we=1, p2n_addr=32'h40, p2n_data=32'hA5A5_0001; host_done one cycle later than edge0+1 with host_err=0; emulator reports 1 entry.
2. Read path:
   - Stimulus: host read addr=32'h0000_1234; emulator echoes address after ~20 clocks.
   - Response: host_rd_data=32'h0000_1234, host_err=0; host_done about 22 cycles after p2n_req; single p2n_req observed.
3. Full stall abort:
   - Stimulus: emulator buf_size=2, which never drains; issue 3 writes.
   - Response: first 2 complete with err=0; third sees p2n_full=1 for TIMEOUT=64 cycles; p2n_req never asserted; host_done with host_err=1.
4. Read timeout:
   - Stimulus: silent responder (n2p_rd_rdy held 0) with full low; host read.
   - Response: host_done exactly TIMEOUT cycles after entering WAIT_RD; host_err=1; host_rd_data=32'hFFFF_FFFF.
   - Repeat with rd_rdy asserted on the timeout edge, n2p_data=32'h5: response host_err=0, host_rd_data=32'h5.
5. Busy rejection:
   - Stimulus: during WAIT_RD, pulse host_req with write addr=32'h99.
   - Response: no extra p2n_req; p2n_addr remains the read address; exactly one host_done.
6. Reset mid-read:
   - Stimulus: drop reset_n asynchronously mid-cycle while in WAIT_RD, then release.
   - Response: all outputs 0 immediately; no host_done; later stray n2p_rd_rdy ignored (host_rd_data stays 0); next write completes normally.
